// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings:
// run request, raw PLL lock, PLL control pins and sequencer status.
interface pll_lock_seq_if;
   logic       enable;
   logic       locked_in;
   logic       pll_areset;
   logic       pll_ena;
   logic       pll_pfdena;
   logic       sys_rst_n;
   logic       lock_ok;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   modport slave (
      input  enable, locked_in,
      output pll_areset, pll_ena, pll_pfdena, sys_rst_n, lock_ok, fault,
             retry_cnt, loss_cnt, state
   );

   modport master (
      output enable, locked_in,
      input  pll_areset, pll_ena, pll_pfdena, sys_rst_n, lock_ok, fault,
             retry_cnt, loss_cnt, state
   );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL bring-up sequencer: reset pulse, filtered lock wait, run and relock on loss.
// Define PLL_LOCK_SEQ_TIMEOUT_EN to enable the per-attempt lock timeout, retries and FAULT.
module pll_lock_seq #(
   parameter int RST_CYCLES     = 16,
   parameter int LOCK_FILTER    = 64,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_RETRY      = 3
) (
   input logic            clk,
   input logic            rst_n,
   pll_lock_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARST  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic [9:0] RST_LAST  = 10'(RST_CYCLES - 1);
   localparam logic [9:0] FILT_LAST = 10'(LOCK_FILTER - 1);

   state_t     state_q, state_d;
   logic       sync1_q, lk_q;
   logic [9:0] cnt_q, cnt_d;
   logic [7:0] loss_q, loss_d;
   logic       pll_areset_q, pll_areset_d;
   logic       pll_ena_q, pll_ena_d;
   logic       pll_pfdena_q, pll_pfdena_d;
   logic       sys_rst_n_q, sys_rst_n_d;
   logic       lock_ok_q, lock_ok_d;

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   logic [15:0] tmo_q, tmo_d;
   logic [3:0]  retry_q, retry_d;
   logic        fault_q, fault_d;
`else
   wire unused_cfg = (TIMEOUT_CYCLES > 0) ^ (MAX_RETRY > 0);
`endif

   // cnt_q times the ARST pulse and doubles as the lock filter in WAIT.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      loss_d  = loss_q;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      tmo_d   = '0;
      retry_d = retry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.enable) state_d = ST_ARST;
         end
         ST_ARST: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == RST_LAST) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = lk_q ? cnt_q + 10'd1 : 10'd0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            tmo_d = tmo_q + 16'd1;
`endif
            if (lk_q && cnt_q == FILT_LAST) begin
               state_d = ST_RUN;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
               retry_d = 4'd0;
            end else if (tmo_q == TMO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_ARST;
               end else begin
                  state_d = ST_FAULT;
               end
`endif
            end
         end
         ST_RUN: begin
            if (!lk_q) begin
               state_d = ST_ARST;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!bus.enable) begin
         state_d = ST_IDLE;
         loss_d  = loss_q;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
         retry_d = 4'd0;
`endif
      end

      if (state_d != state_q) begin
         cnt_d = '0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
         tmo_d = '0;
`endif
      end
   end

   // Output flops load the decode of the next state so they always match state_q.
   always_comb begin
      pll_areset_d = 1'b1;
      pll_ena_d    = 1'b0;
      pll_pfdena_d = 1'b0;
      sys_rst_n_d  = 1'b0;
      lock_ok_d    = 1'b0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      fault_d      = 1'b0;
`endif
      case (state_d)
         ST_ARST: begin
            pll_ena_d = 1'b1;
         end
         ST_WAIT: begin
            pll_areset_d = 1'b0;
            pll_ena_d    = 1'b1;
            pll_pfdena_d = 1'b1;
         end
         ST_RUN: begin
            pll_areset_d = 1'b0;
            pll_ena_d    = 1'b1;
            pll_pfdena_d = 1'b1;
            sys_rst_n_d  = 1'b1;
            lock_ok_d    = 1'b1;
         end
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
         ST_FAULT: begin
            fault_d = 1'b1;
         end
`endif
         default: begin
            pll_areset_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sync1_q      <= 1'b0;
         lk_q         <= 1'b0;
         cnt_q        <= '0;
         loss_q       <= '0;
         pll_areset_q <= 1'b1;
         pll_ena_q    <= 1'b0;
         pll_pfdena_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         lock_ok_q    <= 1'b0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
         tmo_q        <= '0;
         retry_q      <= '0;
         fault_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= bus.locked_in;
         lk_q         <= sync1_q;
         cnt_q        <= cnt_d;
         loss_q       <= loss_d;
         pll_areset_q <= pll_areset_d;
         pll_ena_q    <= pll_ena_d;
         pll_pfdena_q <= pll_pfdena_d;
         sys_rst_n_q  <= sys_rst_n_d;
         lock_ok_q    <= lock_ok_d;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
         tmo_q        <= tmo_d;
         retry_q      <= retry_d;
         fault_q      <= fault_d;
`endif
      end
   end

   assign bus.pll_areset = pll_areset_q;
   assign bus.pll_ena    = pll_ena_q;
   assign bus.pll_pfdena = pll_pfdena_q;
   assign bus.sys_rst_n  = sys_rst_n_q;
   assign bus.lock_ok    = lock_ok_q;
   assign bus.loss_cnt   = loss_q;
   assign bus.state      = state_q;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   assign bus.fault      = fault_q;
   assign bus.retry_cnt  = retry_q;
`else
   assign bus.fault      = 1'b0;
   assign bus.retry_cnt  = 4'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with RST_CYCLES=4, LOCK_FILTER=8, TIMEOUT_CYCLES=32, MAX_RETRY=2.
// Table rows give inputs, cycles to run, and the hand-derived state/retry/loss after those cycles.
module tb_pll_lock_seq;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARST  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   typedef struct {
      logic       en;
      logic       lk;
      int         n;
      logic [2:0] st;
      logic [3:0] retry;
      logic [7:0] loss;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   pll_lock_seq_if bus();

   pll_lock_seq #(
      .RST_CYCLES(4),
      .LOCK_FILTER(8),
      .TIMEOUT_CYCLES(32),
      .MAX_RETRY(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Pin pattern {areset, ena, pfdena, sys_rst_n, lock_ok, fault} each state must show.
   function automatic logic [5:0] expPins(logic [2:0] st);
      case (st)
         S_IDLE:  return 6'b100000;
         S_ARST:  return 6'b110000;
         S_WAIT:  return 6'b011000;
         S_RUN:   return 6'b011110;
         S_FAULT: return 6'b100001;
         default: return 6'b100000;
      endcase
   endfunction

   function automatic vec_t mk(logic en, logic lk, int n, logic [2:0] st,
                               logic [3:0] retry, logic [7:0] loss);
      vec_t v;
      v.en = en; v.lk = lk; v.n = n; v.st = st; v.retry = retry; v.loss = loss;
      return v;
   endfunction

   task automatic checkField(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(string tag, logic [2:0] st, logic [3:0] retry, logic [7:0] loss);
      logic [5:0] p;
      p = expPins(st);
      checkField({tag, ".state"},      {5'd0, bus.state},      {5'd0, st});
      checkField({tag, ".pll_areset"}, {7'd0, bus.pll_areset}, {7'd0, p[5]});
      checkField({tag, ".pll_ena"},    {7'd0, bus.pll_ena},    {7'd0, p[4]});
      checkField({tag, ".pll_pfdena"}, {7'd0, bus.pll_pfdena}, {7'd0, p[3]});
      checkField({tag, ".sys_rst_n"},  {7'd0, bus.sys_rst_n},  {7'd0, p[2]});
      checkField({tag, ".lock_ok"},    {7'd0, bus.lock_ok},    {7'd0, p[1]});
      checkField({tag, ".fault"},      {7'd0, bus.fault},      {7'd0, p[0]});
      checkField({tag, ".retry_cnt"},  {4'd0, bus.retry_cnt},  {4'd0, retry});
      checkField({tag, ".loss_cnt"},   bus.loss_cnt,           loss);
   endtask

   task automatic applyStimulus(vec_t v);
      bus.enable    = v.en;
      bus.locked_in = v.lk;
      repeat (v.n) @(negedge clk);
   endtask

   initial begin
      bus.enable    = 1'b1;
      bus.locked_in = 1'b1;

      // Bring-up with lock present: 4 ARST cycles, 8 filter cycles, then RUN.
      vecs.push_back(mk(1, 1, 0, S_IDLE, 0, 0));
      vecs.push_back(mk(1, 1, 1, S_ARST, 0, 0));
      vecs.push_back(mk(1, 1, 3, S_ARST, 0, 0));
      vecs.push_back(mk(1, 1, 1, S_WAIT, 0, 0));
      vecs.push_back(mk(1, 1, 7, S_WAIT, 0, 0));
      vecs.push_back(mk(1, 1, 1, S_RUN,  0, 0));
      vecs.push_back(mk(1, 1, 4, S_RUN,  0, 0));
      // Lock loss: 3 cycles low, seen after 2-flop sync latency, then relock.
      vecs.push_back(mk(1, 0, 2, S_RUN,  0, 0));
      vecs.push_back(mk(1, 0, 1, S_ARST, 0, 1));
      vecs.push_back(mk(1, 1, 3, S_ARST, 0, 1));
      vecs.push_back(mk(1, 1, 1, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 7, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 1, S_RUN,  0, 1));
      // enable drop returns to IDLE with loss_cnt held.
      vecs.push_back(mk(0, 1, 1, S_IDLE, 0, 1));
      vecs.push_back(mk(0, 1, 3, S_IDLE, 0, 1));
      // One-cycle lock glitch in WAIT restarts the 8-sample filter.
      vecs.push_back(mk(1, 1, 1, S_ARST, 0, 1));
      vecs.push_back(mk(1, 1, 4, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 3, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 0, 1, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 4, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 5, S_WAIT, 0, 1));
      vecs.push_back(mk(1, 1, 1, S_RUN,  0, 1));
      vecs.push_back(mk(1, 0, 2, S_RUN,  0, 1));
      vecs.push_back(mk(1, 0, 1, S_ARST, 0, 2));
      vecs.push_back(mk(1, 0, 4, S_WAIT, 0, 2));
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      // Three 32-cycle timeouts with two retries end in FAULT.
      vecs.push_back(mk(1, 0, 31, S_WAIT,  0, 2));
      vecs.push_back(mk(1, 0, 1,  S_ARST,  1, 2));
      vecs.push_back(mk(1, 0, 4,  S_WAIT,  1, 2));
      vecs.push_back(mk(1, 0, 32, S_ARST,  2, 2));
      vecs.push_back(mk(1, 0, 4,  S_WAIT,  2, 2));
      vecs.push_back(mk(1, 0, 31, S_WAIT,  2, 2));
      vecs.push_back(mk(1, 0, 1,  S_FAULT, 2, 2));
      vecs.push_back(mk(1, 0, 5,  S_FAULT, 2, 2));
      vecs.push_back(mk(1, 1, 5,  S_FAULT, 2, 2));
      vecs.push_back(mk(0, 0, 1,  S_IDLE,  0, 2));
      vecs.push_back(mk(0, 0, 3,  S_IDLE,  0, 2));
      // Filter completes on the same cycle the timeout expires: lock wins.
      vecs.push_back(mk(1, 0, 1,  S_ARST,  0, 2));
      vecs.push_back(mk(1, 0, 4,  S_WAIT,  0, 2));
      vecs.push_back(mk(1, 0, 22, S_WAIT,  0, 2));
      vecs.push_back(mk(1, 1, 9,  S_WAIT,  0, 2));
      vecs.push_back(mk(1, 1, 1,  S_RUN,   0, 2));
`else
      // Without the timeout WAIT holds indefinitely with lock absent.
      vecs.push_back(mk(1, 0, 1000, S_WAIT, 0, 2));
      vecs.push_back(mk(1, 1, 9,    S_WAIT, 0, 2));
      vecs.push_back(mk(1, 1, 1,    S_RUN,  0, 2));
`endif

      $display("[TB] start, %0d table rows", vecs.size());
      repeat (3) @(negedge clk);
      checkOutput("in_reset", S_IDLE, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d", i), vecs[i].st, vecs[i].retry, vecs[i].loss);
      end

      // Asynchronous reset in WAIT must clear outputs before any clock edge.
      bus.locked_in = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("loss_again", S_ARST, 0, 3);
      repeat (4) @(negedge clk);
      checkOutput("wait_pre_rst", S_WAIT, 0, 3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("async_rst", S_IDLE, 0, 0);
      @(negedge clk);
      bus.enable    = 1'b1;
      bus.locked_in = 1'b1;
      rst_n = 1'b1;
      checkOutput("post_rst", S_IDLE, 0, 0);
      @(negedge clk);
      checkOutput("restart", S_ARST, 0, 0);
      bus.enable = 1'b0;
      @(negedge clk);
      checkOutput("en_prio_arst", S_IDLE, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width in clk cycles, range 1..255.
REQ-002 SHALL have parameter LOCK_FILTER, default 64: consecutive synchronized locked samples required before lock is declared, range 1..1023.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum WAIT duration per attempt, range 2..65535.
REQ-004 SHALL have parameter MAX_RETRY, default 3: reset retries before FAULT, range 0..15.
REQ-005 SHALL have input clk, 1 bit: single clock domain for all logic.
REQ-006 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have input enable, 1 bit: level request to run the PLL.
REQ-008 SHALL have input locked_in, 1 bit: PLL locked, asynchronous to clk.
REQ-009 SHALL have output pll_areset, 1 bit: drives the PLL areset pin.
REQ-010 SHALL have output pll_ena, 1 bit: drives the PLL pllena pin.
REQ-011 SHALL have output pll_pfdena, 1 bit: drives the PLL pfdena pin.
REQ-012 SHALL have output sys_rst_n, 1 bit: downstream active-low reset, released only on stable lock.
REQ-013 SHALL have output lock_ok, 1 bit: high in RUN.
REQ-014 SHALL have output fault, 1 bit: high in FAULT.
REQ-015 SHALL have output retry_cnt, 4 bits: retries used in the current attempt series.
REQ-016 SHALL have output loss_cnt, 8 bits: lock losses in RUN, saturating at 255.
REQ-017 SHALL have output state, 3 bits: IDLE=0, ARST=1, WAIT=2, RUN=3, FAULT=4.

Function
REQ-018 SHALL pass locked_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value lk.
REQ-019 All outputs SHALL be registered and decoded from the registered state.
REQ-020 IDLE: pll_areset=1, pll_ena=0, pll_pfdena=0, sys_rst_n=0; with enable=1 sampled, next state SHALL be ARST.
REQ-021 ARST: pll_areset=1, pll_ena=1, pll_pfdena=0; after exactly RST_CYCLES cycles in ARST, next state SHALL be WAIT.
REQ-022 WAIT: pll_areset=0, pll_ena=1, pll_pfdena=1; the filter counter increments on each lk=1 cycle and clears to 0 on any lk=0 cycle.
REQ-023 WAIT: when the filter counter reaches LOCK_FILTER, next state SHALL be RUN and retry_cnt SHALL clear to 0.
REQ-024 RUN: sys_rst_n=1, lock_ok=1, pll_ena=1, pll_pfdena=1, pll_areset=0.
REQ-025 RUN: one cycle of lk=0 SHALL cause next state ARST, deassert sys_rst_n, and increment loss_cnt (saturating at 255).
REQ-026 enable=0 sampled in any state SHALL force next state IDLE; retry_cnt and fault SHALL clear; loss_cnt SHALL be held.
REQ-027 Filter and timeout counters SHALL clear on every state entry.
REQ-028 A lock-filter completion and a timeout in the same cycle SHALL resolve as lock (RUN).
REQ-029 enable=0 SHALL take priority over every other transition.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pll_areset=1, pll_ena=0, pll_pfdena=0, sys_rst_n=0, lock_ok=0, fault=0, retry_cnt=0, loss_cnt=0, and clear the synchronizer and counters, independent of clk.
REQ-031 Release of rst_n mid-operation SHALL restart from IDLE; no state is retained.

Configuration
REQ-032 Macro PLL_LOCK_SEQ_TIMEOUT_EN defined: the timeout counter SHALL run in WAIT.
REQ-033 PLL_LOCK_SEQ_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES with retry_cnt<MAX_RETRY, the block SHALL increment retry_cnt and go to ARST; otherwise it SHALL go to FAULT.
REQ-034 FAULT: pll_areset=1, pll_ena=0, fault=1, sys_rst_n=0; the block SHALL exit only via enable=0 to IDLE.
REQ-035 PLL_LOCK_SEQ_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely; FAULT SHALL be unreachable; fault and retry_cnt SHALL be constant 0; TIMEOUT_CYCLES and MAX_RETRY SHALL be ignored.

Verification (RST_CYCLES=4, LOCK_FILTER=8, TIMEOUT_CYCLES=32, MAX_RETRY=2, macro defined unless noted)
REQ-036 rst_n low, then high with enable=1 and locked_in=1 -> state 0, then 1 for 4 cycles, then 2; sys_rst_n rises 8 lk-high cycles into WAIT; retry_cnt=0.
REQ-037 In WAIT, locked_in toggles 1 for 5 cycles, 0 for 1 cycle, then 1 -> RUN entered only after 8 further consecutive lk=1 cycles.
REQ-038 locked_in held 0 -> after 3 timeouts of 32 cycles and 2 retries, fault=1, state=4, pll_areset=1; then enable=0 -> IDLE with fault=0 and retry_cnt=0.
REQ-039 In RUN, locked_in pulses 0 for 3 cycles -> sys_rst_n=0, loss_cnt=1, state=1, then relock reaches RUN.
REQ-040 rst_n asserted in WAIT -> all outputs reach reset values without a clk edge; with the macro undefined and locked_in=0 for 1000 cycles -> state stays 2 and fault=0.
